// File: rtl/pc_control_unit.sv
// Program-counter and control unit for a small 8-opcode CPU.
// Decodes the current instruction into ALU/register-file control signals
// and sequences the program counter through a two-state RUN/HALT FSM.
// A halt is left only through the asynchronous reset.
module pc_control_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic        WRITEENABLE,
  output logic        IMMSELECT,
  output logic        NEGSELECT,
  output logic [2:0]  INADDRESS,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic [7:0]  IMMEDIATE,
  output logic        HALTED
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // FSM encoding; HALTED is the observable view of this state.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state;
  logic [7:0]  op;
  logic [7:0]  offset;
  logic        we_dec;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic        take_branch;

  assign op     = INSTRUCTION[31:24];
  assign offset = INSTRUCTION[23:16];

  // Register-address fields are 3 bits wide; the upper source bits are
  // reserved in this ISA and intentionally ignored.
  logic unused_src1_hi;
  assign unused_src1_hi = ^INSTRUCTION[15:11];

  assign INADDRESS   = INSTRUCTION[18:16];
  assign OUT1ADDRESS = INSTRUCTION[10:8];
  assign OUT2ADDRESS = INSTRUCTION[2:0];
  assign IMMEDIATE   = INSTRUCTION[7:0];

  assign HALTED = (state == ST_HALT);

  // Opcode decode; unknown opcodes fall through to a NOP (no write, forward).
  always_comb begin
    ALUOP     = ALU_FWD;
    IMMSELECT = 1'b0;
    NEGSELECT = 1'b0;
    we_dec    = 1'b0;
    case (op)
      OP_LOADI: begin IMMSELECT = 1'b1; we_dec = 1'b1; end
      OP_MOV:   begin we_dec = 1'b1; end
      OP_ADD:   begin ALUOP = ALU_ADD; we_dec = 1'b1; end
      OP_SUB:   begin ALUOP = ALU_ADD; NEGSELECT = 1'b1; we_dec = 1'b1; end
      OP_AND:   begin ALUOP = ALU_AND; we_dec = 1'b1; end
      OP_OR:    begin ALUOP = ALU_OR;  we_dec = 1'b1; end
      OP_BEQ:   begin ALUOP = ALU_ADD; NEGSELECT = 1'b1; end
      default:  begin end
    endcase
  end

  // No register write may escape while reset is asserted or the core is halted.
  assign WRITEENABLE = we_dec & ~RESET & ~HALTED;

  // Next-PC arithmetic; both sums wrap modulo 2^32 by construction.
  assign pc_plus4      = PC + 32'd4;
  assign branch_off    = {{22{offset[7]}}, offset, 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign take_branch   = (op == OP_J) || ((op == OP_BEQ) && ZERO);

  // PC and FSM update; reset wins over any edge and returns the core to RUN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC    <= PC_RESET;
      state <= ST_RUN;
    end else if (state == ST_RUN) begin
      if (op == OP_HALT) begin
        state <= ST_HALT;
      end else begin
        PC <= take_branch ? branch_target : pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: directed scenarios plus random instruction
// streams, checked against an instruction-level model through an expected queue.
module tb_pc_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = 32'h3A00_0000;
  logic        ZERO = 1'b0;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic        WRITEENABLE;
  logic        IMMSELECT;
  logic        NEGSELECT;
  logic [2:0]  INADDRESS;
  logic [2:0]  OUT1ADDRESS;
  logic [2:0]  OUT2ADDRESS;
  logic [7:0]  IMMEDIATE;
  logic        HALTED;

  pc_control_unit #(.PC_RESET(32'h0000_0000)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .PC(PC), .ALUOP(ALUOP), .WRITEENABLE(WRITEENABLE), .IMMSELECT(IMMSELECT),
    .NEGSELECT(NEGSELECT), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .IMMEDIATE(IMMEDIATE), .HALTED(HALTED)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [22:0] dec;     // {ALUOP, IMMSELECT, NEGSELECT, WE, INADDR, OUT1, OUT2, IMM}
    logic [31:0] pc;      // PC after the edge
    logic        halted;  // HALTED after the edge
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic mon_busy = 1'b0;

  // instruction-level model state
  logic [31:0] m_pc = 32'h0;
  logic        m_halted = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Control table from the ISA: {aluop, immselect, negselect, writes_register}
  function automatic logic [5:0] isa_ctrl(input logic [7:0] op);
    case (op)
      8'h00:   return {3'b000, 1'b1, 1'b0, 1'b1};
      8'h01:   return {3'b000, 1'b0, 1'b0, 1'b1};
      8'h02:   return {3'b001, 1'b0, 1'b0, 1'b1};
      8'h03:   return {3'b001, 1'b0, 1'b1, 1'b1};
      8'h04:   return {3'b010, 1'b0, 1'b0, 1'b1};
      8'h05:   return {3'b011, 1'b0, 1'b0, 1'b1};
      8'h07:   return {3'b001, 1'b0, 1'b1, 1'b0};
      default: return 6'b0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] instr, input logic zero);
    exp_t        e;
    logic [5:0]  c;
    logic [7:0]  op;
    logic [7:0]  offb;
    int          off_words;
    @(negedge CLK);
    INSTRUCTION = instr;
    ZERO = zero;
    op = instr[31:24];
    offb = instr[23:16];
    c = isa_ctrl(op);
    e.dec = {c[5:3], c[2], c[1], c[0] & ~m_halted,
             instr[18:16], instr[10:8], instr[2:0], instr[7:0]};
    if (!m_halted) begin
      if (op == 8'hFF) begin
        m_halted = 1'b1;
      end else if (op == 8'h06 || (op == 8'h07 && zero)) begin
        off_words = $signed(offb);
        m_pc = m_pc + 32'd4 + 32'(off_words * 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc;
    e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t cur;
    forever begin
      @(negedge CLK);
      #4;
      if (exp_q.size() > 0) begin
        mon_busy = 1'b1;
        cur = exp_q.pop_front();
        check("decode", 64'({ALUOP, IMMSELECT, NEGSELECT, WRITEENABLE,
                             INADDRESS, OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE}), 64'(cur.dec));
        @(posedge CLK);
        #1;
        check("pc", 64'(PC), 64'(cur.pc));
        check("halted", 64'(HALTED), 64'(cur.halted));
        mon_busy = 1'b0;
      end
    end
  end

  // Ends on a negedge once all queued expectations have been compared.
  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((exp_q.size() != 0 || mon_busy) && n < 50);
    if (n >= 50) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Mid-cycle asynchronous reset, held over two edges, released after an edge.
  task automatic apply_reset();
    wait_drain();
    #2;
    RESET = 1'b1;
    #1;
    check("rst_pc", 64'(PC), 64'h0);
    check("rst_we", 64'(WRITEENABLE), 64'h0);
    check("rst_halted", 64'(HALTED), 64'h0);
    m_pc = 32'h0;
    m_halted = 1'b0;
    INSTRUCTION = 32'h0605_0000;  // a jump that must be ignored during reset
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("rst_hold_pc", 64'(PC), 64'h0);
      check("rst_hold_halted", 64'(HALTED), 64'h0);
      check("rst_hold_we", 64'(WRITEENABLE), 64'h0);
    end
    #1;
    RESET = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] op;
    logic [7:0] offs;
    apply_reset();

    // sequential: loadi, add, sub, or
    drive(32'h0001_0005, 1'b0);
    drive(32'h0202_0103, 1'b1);
    drive(32'h0303_0201, 1'b0);
    drive(32'h0504_0302, 1'b0);
    wait_drain();
    check("pre_reset_pc", 64'(PC), 64'h10);
    apply_reset();

    // unknown opcodes up to 0x20, then beq both ways
    repeat (8) drive(32'h3A01_0203, 1'b1);
    drive(32'h0703_0102, 1'b1);  // 0x20 -> 0x30
    drive(32'h06FB_0000, 1'b0);  // 0x30 -> 0x20
    drive(32'h0703_0102, 1'b0);  // 0x20 -> 0x24
    // backward jumps and wrap
    drive(32'h0606_0000, 1'b0);  // 0x24 -> 0x40
    drive(32'h06FE_0000, 1'b1);  // 0x40 -> 0x3C
    drive(32'h06F0_0000, 1'b0);  // 0x3C -> 0x00
    drive(32'h0680_0000, 1'b0);  // 0x00 -> 0xFFFFFE04
    // offset edge cases
    drive(32'h0600_0000, 1'b0);  // +0 -> PC+4
    drive(32'h06FF_0000, 1'b0);  // -1 -> self loop
    drive(32'h07FF_0000, 1'b1);  // taken beq self loop
    drive(32'h067F_0000, 1'b0);  // +127 words

    // random instruction stream (no halt)
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h00; 1: op = 8'h01; 2: op = 8'h02; 3: op = 8'h03;
        4: op = 8'h04; 5: op = 8'h05; 6: op = 8'h06; 7, 8: op = 8'h07;
        default: op = 8'($urandom_range(8, 254));
      endcase
      case ($urandom_range(0, 5))
        0: offs = 8'h00; 1: offs = 8'hFF; 2: offs = 8'h80; 3: offs = 8'h7F;
        default: offs = 8'($urandom_range(0, 255));
      endcase
      drive({op, offs, 16'($urandom_range(0, 65535))}, 1'($urandom_range(0, 1)));
    end
    apply_reset();

    // halt at 0x08, add presented for 5 edges, then reset and resume
    drive(32'h3A00_0000, 1'b0);
    drive(32'h3A00_0000, 1'b0);
    drive(32'hFF00_0000, 1'b1);
    repeat (5) drive(32'h0201_0203, 1'b1);
    apply_reset();
    drive(32'h0002_0007, 1'b0);
    drive(32'h0703_0000, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
